// File: rtl/inst_mem_loader.sv
// Instruction memory loader: turns a valid/ready stream of 32-bit words into
// little-endian byte writes (byte 0 at the lowest address) for the
// byte-addressed instruction memory. It is busy only while a program loads.
//
// Optional build macro LOADER_CHECKSUM_EN: when defined, Load_Checksum holds
// the mod-2^32 sum of the words accepted since the last Load_Start. When it is
// not defined, Load_Checksum is tied to zero and no adder is built.
module inst_mem_loader #(
  parameter int unsigned          ADDR_WIDTH = 64,
  parameter int unsigned          MEM_BYTES  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Load_Start,
  input  logic [31:0]           Load_Word,
  input  logic                  Load_Valid,
  input  logic                  Load_Last,
  output logic                  Load_Ready,
  output logic                  Mem_Write_En,
  output logic [ADDR_WIDTH-1:0] Mem_Write_Addr,
  output logic [7:0]            Mem_Write_Data,
  output logic                  Load_Busy,
  output logic                  Load_Done,
  output logic                  Load_Full,
  output logic [31:0]           Load_Checksum
);

  // One past the last byte of the memory window.
  localparam logic [ADDR_WIDTH-1:0] EndAddr = BASE_ADDR + ADDR_WIDTH'(MEM_BYTES);

  typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             word_q;
  logic                    last_q;
  logic [1:0]              idx_q;
  logic                    ready_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [7:0]              wdata_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    full_q;

  logic                    start_evt;
  logic                    handshake;
  logic [1:0]              idx_nxt;
  logic [ADDR_WIDTH-1:0]   addr_plus4;

  // Session start and word handshake events, plus next byte lane and next word address.
  always_comb begin
    start_evt  = (state_q == StIdle) && Load_Start;
    handshake  = (state_q == StAccept) && Load_Valid && ready_q;
    idx_nxt    = idx_q + 2'd1;
    addr_plus4 = addr_q + ADDR_WIDTH'(4);
  end

  // Loader FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= 2'd0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_evt) begin
            state_q <= StAccept;
            addr_q  <= BASE_ADDR;
            full_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StAccept: begin
          if (handshake) begin
            state_q <= StWrite;
            word_q  <= Load_Word;
            last_q  <= Load_Last;
            idx_q   <= 2'd0;
            ready_q <= 1'b0;
            // Byte 0 goes out in the first WRITE cycle.
            we_q    <= 1'b1;
            waddr_q <= addr_q;
            wdata_q <= Load_Word[7:0];
          end
        end
        StWrite: begin
          if (idx_q != 2'd3) begin
            idx_q   <= idx_nxt;
            waddr_q <= addr_q + ADDR_WIDTH'(idx_nxt);
            wdata_q <= word_q[{idx_nxt, 3'b000} +: 8];
          end else begin
            we_q   <= 1'b0;
            idx_q  <= 2'd0;
            addr_q <= addr_plus4;
            if (last_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else if (addr_plus4 == EndAddr) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              full_q  <= 1'b1;
            end else begin
              state_q <= StAccept;
              ready_q <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  // Running word sum: cleared on session start, held after DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else if (start_evt) begin
      csum_q <= '0;
    end else if (handshake) begin
      csum_q <= csum_q + Load_Word;
    end
  end

  assign Load_Checksum = csum_q;
`else
  assign Load_Checksum = '0;
`endif

  assign Load_Ready     = ready_q;
  assign Mem_Write_En   = we_q;
  assign Mem_Write_Addr = waddr_q;
  assign Mem_Write_Data = wdata_q;
  assign Load_Busy      = busy_q;
  assign Load_Done      = done_q;
  assign Load_Full      = full_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: inputs change and outputs are sampled on
// the falling clock edge; expected values are hand-computed constants.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        Load_Start;
  logic [31:0] Load_Word;
  logic        Load_Valid;
  logic        Load_Last;
  logic        Load_Ready;
  logic        Mem_Write_En;
  logic [63:0] Mem_Write_Addr;
  logic [7:0]  Mem_Write_Data;
  logic        Load_Busy;
  logic        Load_Done;
  logic        Load_Full;
  logic [31:0] Load_Checksum;

  int n_checks = 0;
  int n_bad    = 0;

  logic [7:0] mem [16];

  always #5 clk = ~clk;

  inst_mem_loader dut (
    .clk            (clk),
    .reset          (reset),
    .Load_Start     (Load_Start),
    .Load_Word      (Load_Word),
    .Load_Valid     (Load_Valid),
    .Load_Last      (Load_Last),
    .Load_Ready     (Load_Ready),
    .Mem_Write_En   (Mem_Write_En),
    .Mem_Write_Addr (Mem_Write_Addr),
    .Mem_Write_Data (Mem_Write_Data),
    .Load_Busy      (Load_Busy),
    .Load_Done      (Load_Done),
    .Load_Full      (Load_Full),
    .Load_Checksum  (Load_Checksum)
  );

  // Byte memory model fed by the write port.
  always @(posedge clk) begin
    if (Mem_Write_En && Mem_Write_Addr < 64'd16) mem[Mem_Write_Addr[3:0]] <= Mem_Write_Data;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_session();
    Load_Start = 1'b1;
    step();
    Load_Start = 1'b0;
  endtask

  // Offer one word and check its four byte writes at byte address a.
  task automatic send_word(input logic [31:0] w, input logic last, input logic [63:0] a);
    int n = 0;
    while (!Load_Ready && n < 20) begin
      step();
      n++;
    end
    check("ready_wait", {63'd0, Load_Ready}, 64'd1);
    Load_Valid = 1'b1;
    Load_Word  = w;
    Load_Last  = last;
    step();
    Load_Valid = 1'b0;
    Load_Last  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("wr_en",   {63'd0, Mem_Write_En}, 64'd1);
      check("wr_addr", Mem_Write_Addr, a + 64'(k));
      check("wr_data", {56'd0, Mem_Write_Data}, {56'd0, w[8*k +: 8]});
      check("wr_rdy",  {63'd0, Load_Ready}, 64'd0);
      step();
    end
  endtask

  function automatic logic [31:0] csum_exp(input logic [31:0] v);
`ifdef LOADER_CHECKSUM_EN
    return v;
`else
    return (v & 32'd0);
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    Load_Start = 1'b0;
    Load_Word  = '0;
    Load_Valid = 1'b0;
    Load_Last  = 1'b0;
    step();
    step();
    check("rst_ready", {63'd0, Load_Ready}, 64'd0);
    check("rst_we",    {63'd0, Mem_Write_En}, 64'd0);
    check("rst_addr",  Mem_Write_Addr, 64'd0);
    check("rst_busy",  {63'd0, Load_Busy}, 64'd0);
    check("rst_csum",  {32'd0, Load_Checksum}, 64'd0);
    reset = 1'b0;
    // Valid in IDLE is ignored.
    Load_Valid = 1'b1;
    step();
    Load_Valid = 1'b0;
    check("idle_valid_ready", {63'd0, Load_Ready}, 64'd0);
    check("idle_valid_we",    {63'd0, Mem_Write_En}, 64'd0);

    // Single word with Last.
    start_session();
    check("t1_ready", {63'd0, Load_Ready}, 64'd1);
    check("t1_busy",  {63'd0, Load_Busy}, 64'd1);
    send_word(32'h02853483, 1'b1, 64'd0);
    check("t1_done",  {63'd0, Load_Done}, 64'd1);
    check("t1_we",    {63'd0, Mem_Write_En}, 64'd0);
    check("t1_full",  {63'd0, Load_Full}, 64'd0);
    check("t1_csum",  {32'd0, Load_Checksum}, {32'd0, csum_exp(32'h02853483)});
    step();
    check("t1_done_end", {63'd0, Load_Done}, 64'd0);
    check("t1_busy_end", {63'd0, Load_Busy}, 64'd0);

    // Four words fill the memory.
    start_session();
    check("t2_csum_clr", {32'd0, Load_Checksum}, 64'd0);
    send_word(32'h02853483, 1'b0, 64'd0);
    send_word(32'h009A84B3, 1'b0, 64'd4);
    send_word(32'h00148493, 1'b0, 64'd8);
    send_word(32'h02953423, 1'b0, 64'd12);
    check("t2_done", {63'd0, Load_Done}, 64'd1);
    check("t2_full", {63'd0, Load_Full}, 64'd1);
    check("t2_csum", {32'd0, Load_Checksum}, {32'd0, csum_exp(32'h05C971EC)});
    check("t2_fetch8", {32'd0, mem[11], mem[10], mem[9], mem[8]}, 64'h00148493);
    check("t2_fetch0", {32'd0, mem[3], mem[2], mem[1], mem[0]}, 64'h02853483);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_ready_after", {63'd0, Load_Ready}, 64'd0);
      check("t2_full_sticky", {63'd0, Load_Full}, 64'd1);
      check("t2_done_once",   {63'd0, Load_Done}, 64'd0);
    end

    // Stalled valid keeps ready high with no writes.
    start_session();
    check("t3_full_clr", {63'd0, Load_Full}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("t3_stall_ready", {63'd0, Load_Ready}, 64'd1);
      check("t3_stall_we",    {63'd0, Mem_Write_En}, 64'd0);
      step();
    end
    send_word(32'h11223344, 1'b1, 64'd0);
    check("t3_done", {63'd0, Load_Done}, 64'd1);
    step();

    // Load_Start during WRITE is ignored.
    start_session();
    Load_Valid = 1'b1;
    Load_Word  = 32'hAABBCCDD;
    Load_Last  = 1'b0;
    step();
    Load_Valid = 1'b0;
    Load_Start = 1'b1;
    check("t4_addr0", Mem_Write_Addr, 64'd0);
    step();
    Load_Start = 1'b0;
    check("t4_addr1", Mem_Write_Addr, 64'd1);
    check("t4_data1", {56'd0, Mem_Write_Data}, 64'hCC);
    step();
    step();
    step();
    check("t4_accept", {63'd0, Load_Ready}, 64'd1);
    send_word(32'h55667788, 1'b1, 64'd4);
    check("t4_done", {63'd0, Load_Done}, 64'd1);
    step();

    // Reset at byte index 2.
    start_session();
    Load_Valid = 1'b1;
    Load_Word  = 32'hCAFEF00D;
    Load_Last  = 1'b1;
    step();
    Load_Valid = 1'b0;
    Load_Last  = 1'b0;
    step();
    step();
    check("t5_addr2", Mem_Write_Addr, 64'd2);
    check("t5_data2", {56'd0, Mem_Write_Data}, 64'hFE);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_we",    {63'd0, Mem_Write_En}, 64'd0);
    check("t5_busy",  {63'd0, Load_Busy}, 64'd0);
    check("t5_addr",  Mem_Write_Addr, 64'd0);
    check("t5_data",  {56'd0, Mem_Write_Data}, 64'd0);
    check("t5_ready", {63'd0, Load_Ready}, 64'd0);
    check("t5_full",  {63'd0, Load_Full}, 64'd0);
    check("t5_csum",  {32'd0, Load_Checksum}, 64'd0);
    check("t5_mem1",  {56'd0, mem[1]}, 64'hF0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_done", {63'd0, Load_Done}, 64'd0);
    end

    // Checksum wraps modulo 2^32.
    start_session();
    send_word(32'hFFFFFFFF, 1'b0, 64'd0);
    send_word(32'h00000002, 1'b1, 64'd4);
    check("t6_csum", {32'd0, Load_Checksum}, {32'd0, csum_exp(32'h00000001)});
    step();
    step();
    check("t6_csum_hold", {32'd0, Load_Checksum}, {32'd0, csum_exp(32'h00000001)});

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Writer side of the byte-addressed instruction memory. Accepts 32-bit instruction words over a valid/ready stream and writes each word as four byte writes, little-endian (word[7:0] at address A, word[31:24] at A+3), so a 4-byte instruction fetch at A returns the original word. Sits between the boot/debug path and the instruction memory write port; active only while a program is being loaded.

Parameters:
ADDR_WIDTH, 64, width of Mem_Write_Addr; matches the instruction fetch address width.
MEM_BYTES, 16, instruction memory size in bytes; must be a multiple of 4.
BASE_ADDR, 0, first byte address written after Load_Start; must be 4-aligned.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
Load_Start  input  1  begin a load session at BASE_ADDR (sampled in IDLE only)
Load_Word  input  32  instruction word to write
Load_Valid  input  1  Load_Word is valid
Load_Last  input  1  qualifies the current word as the final one of the session
Load_Ready  output  1  loader can accept a word this cycle
Mem_Write_En  output  1  byte write strobe to instruction memory
Mem_Write_Addr  output  ADDR_WIDTH  byte address of current write
Mem_Write_Data  output  8  byte to write
Load_Busy  output  1  session in progress (not IDLE)
Load_Done  output  1  one-cycle pulse at session end
Load_Full  output  1  sticky: session ended because MEM_BYTES was reached
Load_Checksum  output  32  running word checksum (see Optional Feature)

Behaviour:
- Reset: state IDLE; Load_Ready, Mem_Write_En, Load_Busy, Load_Done, Load_Full = 0; Mem_Write_Addr = 0; Mem_Write_Data = 0; Load_Checksum = 0; byte index = 0.
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: Load_Start=1 -> ACCEPT next cycle; address counter <= BASE_ADDR; Load_Full <= 0; checksum <= 0. Load_Valid in IDLE ignored.
- ACCEPT: Load_Ready=1 (registered, asserted in the same cycle as the ACCEPT state). Handshake = Load_Valid & Load_Ready. On handshake: capture Load_Word and Load_Last, go WRITE, byte index <= 0. No handshake -> stay.
- WRITE: exactly 4 cycles, byte index k = 0..3; Mem_Write_En=1, Mem_Write_Addr = addr+k, Mem_Write_Data = word[8k+7:8k]. Load_Ready=0 throughout. After k=3: addr <= addr+4; if captured Last=1 -> DONE; else if addr+4 == BASE_ADDR+MEM_BYTES -> Load_Full<=1, DONE; else ACCEPT.
- Throughput: 5 cycles per word (1 accept + 4 writes) minimum.
- DONE: Load_Done=1 for one cycle, Mem_Write_En=0 -> IDLE. Load_Busy=1 in ACCEPT, WRITE, DONE.
- Load_Start while not IDLE: ignored.
- Last and full on same word: DONE once, Load_Full=1.
- Address arithmetic modulo 2^ADDR_WIDTH; no wrap to BASE_ADDR within a session.
- Reset mid-WRITE: write strobe drops next cycle; bytes already written stay in memory; no completion pulse.
- Mem_Write_En never asserted outside WRITE.

Optional Feature:
Macro LOADER_CHECKSUM_EN. Defined: Load_Checksum = mod-2^32 sum of all words accepted since the last Load_Start, updated the cycle after each handshake and held after DONE until the next Load_Start or reset. Undefined: Load_Checksum tied to 0, no adder generated.

Test Plan:
- Reset then Load_Start, one word 0x02853483 with Last=1 -> writes (0,0x83),(1,0x34),(2,0x85),(3,0x02) on 4 consecutive cycles; Load_Done pulse; Load_Full=0.
- Four words 0x02853483, 0x009A84B3, 0x00148493, 0x02953423, no Last -> 16 byte writes at 0..15; after the 4th word, Load_Full=1, Load_Done pulses, and Load_Ready stays 0 afterward. A 4-byte fetch at 8 returns 0x00148493.
- Load_Valid held low for 3 cycles in ACCEPT -> Load_Ready stays 1, no writes; word accepted on the first valid cycle.
- Load_Start pulsed during WRITE -> ignored; addresses continue without restarting at BASE_ADDR.
- Reset asserted at byte index 2 -> Mem_Write_En=0 and state IDLE next cycle; all outputs at reset values.
- With LOADER_CHECKSUM_EN: words 0xFFFFFFFF and 0x00000002 -> Load_Checksum=0x00000001; without the macro -> 0.
